// File: rtl/pri_decoder.sv
// pri_decoder: rebuilds a WIDTH-bit mask from a bit index, either one-hot
// (bit idx only) or thermometer (bits idx..0). Two-stage pipeline with
// valid/ready on both sides, an out-of-range flag and a decode counter.
module pri_decoder #(
   parameter int WIDTH     = 56,
   parameter int WIDTH_LOG = 6,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH_LOG-1:0] in_idx,
   input  logic                 in_none,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_mask,
   output logic                 out_err,
   output logic [CNT_W-1:0]     dec_count
);

   // The mask is built from 8-bit groups; the upper index bits pick a group,
   // the low three bits pick a position inside it.
   localparam int NGRP = (WIDTH + 7) / 8;
   localparam int HI_W = WIDTH_LOG - 3;

   logic                 adv;
   logic [HI_W-1:0]      hi_idx;
   logic [NGRP-1:0]      grp_next;
   logic [NGRP-1:0]      fill_next;
   logic                 err_next;

   logic                 s1_valid_reg;
   logic                 s1_mode_reg;
   logic                 s1_none_reg;
   logic                 s1_err_reg;
   logic [NGRP-1:0]      s1_grp_reg;
   logic [NGRP-1:0]      s1_fill_reg;
   logic [2:0]           s1_lo_reg;

   logic [7:0]           lo_exp;
   logic [NGRP*8-1:0]    mask_full;
   logic [WIDTH-1:0]     mask_next;

   logic                 out_valid_reg;
   logic [WIDTH-1:0]     out_mask_reg;
   logic                 out_err_reg;
   logic [CNT_W-1:0]     dec_count_reg;

   // Both stages move together whenever the output slot is free or drained.
   assign adv      = !out_valid_reg || out_ready;
   assign in_ready = adv && !rst;

   assign hi_idx   = in_idx[WIDTH_LOG-1:3];
   assign err_next = (32'(in_idx) >= WIDTH);

   // Group select and below-group fill; fill only applies in thermometer mode.
   generate
      for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
         assign grp_next[gi]  = (hi_idx == HI_W'(gi));
         assign fill_next[gi] = in_mode && (HI_W'(gi) < hi_idx);
      end
   endgenerate

   // Stage 1: register the group decode, low bits and side flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_mode_reg  <= 1'b0;
         s1_none_reg  <= 1'b0;
         s1_err_reg   <= 1'b0;
         s1_grp_reg   <= '0;
         s1_fill_reg  <= '0;
         s1_lo_reg    <= '0;
      end else if (adv) begin
         s1_valid_reg <= in_valid;
         s1_mode_reg  <= in_mode;
         s1_none_reg  <= in_none;
         s1_err_reg   <= err_next;
         s1_grp_reg   <= grp_next;
         s1_fill_reg  <= fill_next;
         s1_lo_reg    <= in_idx[2:0];
      end
   end

   // 3-to-8 expand of the low bits: single bit, or that bit and everything below.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lo
         assign lo_exp[gi] = s1_mode_reg ? (3'(gi) <= s1_lo_reg)
                                         : (3'(gi) == s1_lo_reg);
      end
   endgenerate

   // Selected group gets the expanded pattern; lower groups are all-ones when filled.
   generate
      for (genvar gi = 0; gi < NGRP; gi++) begin : g_mask
         assign mask_full[gi*8 +: 8] = s1_grp_reg[gi] ? lo_exp : {8{s1_fill_reg[gi]}};
      end
   endgenerate

   assign mask_next = (s1_none_reg || s1_err_reg) ? '0 : mask_full[WIDTH-1:0];

   // Stage 2: output register; holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_mask_reg  <= '0;
         out_err_reg   <= 1'b0;
      end else if (adv) begin
         out_valid_reg <= s1_valid_reg;
         out_mask_reg  <= mask_next;
         out_err_reg   <= s1_err_reg && !s1_none_reg;
      end
   end

   // Count completed output handshakes, errored results included; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_count_reg <= '0;
      end else if (out_valid_reg && out_ready) begin
         dec_count_reg <= dec_count_reg + 1'b1;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_mask  = out_mask_reg;
   assign out_err   = out_err_reg;
   assign dec_count = dec_count_reg;

endmodule

// File: tb/tb_pri_decoder.sv
// tb_pri_decoder: table-driven vectors plus hand-written sequences; expected
// results are queued at input handshake and compared at output handshake.
module tb_pri_decoder;

   localparam int WIDTH     = 56;
   localparam int WIDTH_LOG = 6;
   localparam int CNT_W     = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH_LOG-1:0] in_idx;
   logic                 in_none;
   logic                 in_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_mask;
   logic                 out_err;
   logic [CNT_W-1:0]     dec_count;

   always #5 clk = ~clk;

   pri_decoder #(.WIDTH(WIDTH), .WIDTH_LOG(WIDTH_LOG), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
      .in_none(in_none), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
      .out_err(out_err), .dec_count(dec_count)
   );

   typedef struct {
      logic [5:0]  idx;
      logic        none;
      logic        mode;
      logic [55:0] mask;
      logic        err;
   } vec_t;

   typedef struct {
      logic [55:0] mask;
      logic        err;
      logic [5:0]  idx;
      logic        none;
      logic        mode;
      int          step;
      logic        lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          step_no = 0;
   int          model_cnt = 0;
   logic        chk_lat = 1'b0;
   logic        prev_stall = 1'b0;
   logic [55:0] held_mask;
   logic        held_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_no);
      end
   endtask

   function automatic logic [55:0] ref_mask(input logic [5:0] idx, input logic none, input logic mode);
      logic [55:0] one;
      int          sh;
      one = 56'd1;
      sh  = int'(idx);
      if (none || sh >= WIDTH) return '0;
      if (mode) return (one << (sh + 1)) - one;
      return one << sh;
   endfunction

   function automatic int msb_of(input logic [55:0] m);
      for (int b = 55; b >= 0; b--) if (m[b]) return b;
      return -1;
   endfunction

   // One clock: drive at negedge, sample 1 time unit later, account for the
   // handshakes that the following posedge will perform.
   task automatic step(input logic r, input logic v, input logic [5:0] idx, input logic none,
                       input logic mode, input logic ordy, input logic [55:0] emask,
                       input logic eerr, output logic accepted);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = v; in_idx = idx; in_none = none; in_mode = mode; out_ready = ordy;
      #1;
      accepted = 1'b0;
      step_no++;
      if (r) begin
         check("in_ready_in_reset", 64'(in_ready), 64'd0);
         sb.delete();
         model_cnt  = 0;
         prev_stall = 1'b0;
      end else begin
         check("dec_count", 64'(dec_count), 64'(model_cnt));
         check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
         if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_mask", 64'(out_mask), 64'(held_mask));
            check("hold_err", 64'(out_err), 64'(held_err));
         end
         prev_stall = out_valid && !out_ready;
         held_mask  = out_mask;
         held_err   = out_err;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               $display("OUT step=%0d idx=%0d mode=%0d none=%0d mask=%014h err=%0d", step_no,
                        e.idx, e.mode, e.none, out_mask, out_err);
               check("out_mask", 64'(out_mask), 64'(e.mask));
               check("out_err", 64'(out_err), 64'(e.err));
               if (e.lat) check("latency", 64'(step_no - e.step), 64'd2);
               if (!e.none && !e.err) begin
                  check("msb_index", 64'(msb_of(out_mask)), 64'(e.idx));
                  check("popcount", 64'($countones(out_mask)),
                        e.mode ? 64'(e.idx) + 64'd1 : 64'd1);
               end
               model_cnt++;
            end
         end
         if (v && in_ready) begin
            e.mask = emask; e.err = eerr; e.idx = idx; e.none = none; e.mode = mode;
            e.step = step_no; e.lat = chk_lat;
            sb.push_back(e);
            accepted = 1'b1;
         end
      end
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, ordy, '0, 1'b0, acc);
   endtask

   task automatic send(input vec_t vec);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++)
         step(1'b0, 1'b1, vec.idx, vec.none, vec.mode, 1'b1, vec.mask, vec.err, acc);
      if (!acc) check("send_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb.size() > 0; t++) idle(1'b1);
      check("drain_empty", 64'(sb.size()), 64'd0);
      idle(1'b1);
      idle(1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      vec_t v;
      vec_t pend[$];
      logic acc;

      tbl[0] = '{6'd0,  1'b0, 1'b0, 56'h1,               1'b0};
      tbl[1] = '{6'd1,  1'b0, 1'b0, 56'h2,               1'b0};
      tbl[2] = '{6'd5,  1'b0, 1'b0, 56'h20,              1'b0};
      tbl[3] = '{6'd51, 1'b0, 1'b1, 56'h0F_FFFF_FFFF_FFFF, 1'b0};
      tbl[4] = '{6'd55, 1'b0, 1'b1, 56'hFF_FFFF_FFFF_FFFF, 1'b0};
      tbl[5] = '{6'd17, 1'b1, 1'b0, 56'h0,               1'b0};
      tbl[6] = '{6'd56, 1'b0, 1'b0, 56'h0,               1'b1};
      tbl[7] = '{6'd63, 1'b0, 1'b0, 56'h0,               1'b1};

      rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_none = 1'b0; in_mode = 1'b0; out_ready = 1'b1;

      // Reset, then confirm the cleared output state.
      step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0, acc);
      step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0, acc);
      idle(1'b1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_mask", 64'(out_mask), 64'd0);
      check("reset_out_err", 64'(out_err), 64'd0);

      // Table vectors streamed back to back with the consumer always ready.
      chk_lat = 1'b1;
      for (int i = 0; i < 8; i++) send(tbl[i]);
      drain();
      check("count_after_table", 64'(dec_count), 64'd8);

      // Backpressure: consumer stalls for 5 cycles while 4 requests are offered.
      chk_lat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v.idx = 6'(10 * (i + 1)); v.none = 1'b0; v.mode = i[0];
         v.mask = ref_mask(v.idx, 1'b0, v.mode); v.err = 1'b0;
         pend.push_back(v);
      end
      for (int t = 0; t < 40 && (pend.size() > 0 || sb.size() > 0); t++) begin
         if (pend.size() > 0)
            step(1'b0, 1'b1, pend[0].idx, pend[0].none, pend[0].mode, t >= 5,
                 pend[0].mask, pend[0].err, acc);
         else
            step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0, acc);
         if (t >= 2 && t <= 4) check("in_ready_full", 64'(in_ready), 64'd0);
         if (acc) void'(pend.pop_front());
      end
      check("stall_pending", 64'(pend.size()), 64'd0);
      drain();
      check("count_after_stall", 64'(dec_count), 64'd12);

      // Reset with two results in flight, then a fresh request.
      v = '{6'd7, 1'b0, 1'b0, 56'h80, 1'b0};
      send(v);
      v = '{6'd9, 1'b0, 1'b0, 56'h200, 1'b0};
      send(v);
      step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, '0, 1'b0, acc);
      idle(1'b1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_mask", 64'(out_mask), 64'd0);
      check("midrst_dec_count", 64'(dec_count), 64'd0);
      chk_lat = 1'b1;
      v = '{6'd3, 1'b0, 1'b0, 56'h8, 1'b0};
      send(v);
      drain();

      // Full sweep in both modes against the reference model.
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < WIDTH; i++) begin
            v.idx = 6'(i); v.none = 1'b0; v.mode = m[0];
            v.mask = ref_mask(v.idx, 1'b0, v.mode); v.err = 1'b0;
            send(v);
         end
      end
      drain();
      check("count_after_sweep", 64'(dec_count), 64'd113);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pri_decoder.md
Name: pri_decoder

Overview:
- Inverse of the team's 56-bit MSB priority encoder: takes a 6-bit bit index and rebuilds a 56-bit mask.
- The mask is either one-hot (bit idx only) or thermometer (bits idx..0).
- Sits downstream of index-producing logic to regenerate diff-style vectors.
- Two-stage pipeline with valid/ready handshakes on both sides, an out-of-range flag, and a completed-decode counter.

Parameters:
- WIDTH, 56, mask width in bits.
- WIDTH_LOG, 6, index width; must satisfy 2^WIDTH_LOG >= WIDTH.
- CNT_W, 32, width of the decode counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts a request this cycle.
- in_idx  input  WIDTH_LOG  bit index to decode.
- in_none  input  1  source vector was all-zero; output mask is 0, not an error.
- in_mode  input  1  0 = one-hot, 1 = thermometer.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_mask  output  WIDTH  decoded mask.
- out_err  output  1  in_idx >= WIDTH.
- dec_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (rst sampled high at posedge):
  - s1_valid, out_valid, out_err cleared to 0; out_mask cleared to 0; dec_count cleared to 0.
  - in_ready is forced 0 while rst is high.
  - Any in-flight requests are dropped. No output handshake occurs in the reset cycle.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv && !rst (combinational).
- Input handshake: in_valid && in_ready.
- Stage 1, registered when adv:
  - Captures in_valid as s1_valid, plus mode and none.
  - err1 = (in_idx >= WIDTH).
  - Group select: upper bits in_idx[WIDTH_LOG-1:3] decoded to 8-bit-group one-hot grp[6:0] (7 groups cover bits 0..55).
  - Group fill: in thermometer mode, fill[g] = (g < in_idx[5:3]).
  - Low bits in_idx[2:0] are kept.
- Stage 2, registered when adv:
  - out_valid <= s1_valid.
  - Inside the selected group, a 3-to-8 expand of the low bits: one-hot sets bit lo only; thermometer sets bits lo..0.
  - All groups below the selected one are all-ones in thermometer mode.
  - If none or err1: out_mask <= 0.
  - out_err <= err1 && !none.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready is held high. Throughput is 1 result per cycle.
- Backpressure:
  - While out_valid && !out_ready, out_mask, out_err and out_valid hold stable and stage 1 holds.
  - in_ready = 0 in that state. No request is lost or duplicated.
- Bubbles: when s1_valid = 0 and adv = 1, out_valid drops to 0 on the next edge.
- dec_count:
  - Increments by 1 on each out_valid && out_ready.
  - Wraps from 2^CNT_W-1 to 0.
  - Results with out_err = 1 are counted.
- Result invariants:
  - For any accepted request without none or err: the MSB index of out_mask equals in_idx.
  - One-hot results have popcount 1.
  - Thermometer results have popcount in_idx+1.
- Simultaneous events:
  - Input and output handshakes in the same cycle are both honoured.
  - rst has priority over both handshakes.

Test Plan:
- Reset then stream idx=0,1,5 one-hot with out_ready=1 -> out_valid at cycles +2,+3,+4 with masks 0x1, 0x2, 0x20; out_err=0; dec_count=3.
- Thermometer idx=51 and idx=55 -> 0x0F_FFFF_FFFF_FFFF (52 ones), then all-ones (56 ones); out_err=0.
- in_none=1 with idx=17, then idx=56 and idx=63 one-hot -> masks 0,0,0; out_err 0,1,1; dec_count advances by 3.
- Hold out_ready=0 for 5 cycles with 4 requests offered -> in_ready low once both stages are full; out_mask stable. On release, results appear in order, once each.
- Assert rst mid-stream with 2 results in flight -> next cycle out_valid=0, dec_count=0, out_mask=0. Post-reset request idx=3 yields 0x8 two cycles after acceptance.
- Sweep idx 0..55 in both modes against a reference model -> every mask bit-exact, MSB index equals idx, popcount matches mode.
